// File: rtl/midiuart_rx.sv
// 8N1 serial receiver for the MIDI link: synchronised input, mid-bit sampling
// state machine, receive FIFO and a picorv32-style valid/ready register port.
`timescale 1ns/1ps
module midiuart_rx #(
  parameter int DEFAULT_DIV = 1333,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_rx,
  input  logic        valid,
  output logic        ready,
  input  logic [1:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_WAITHI = 3'd4;

  logic          r_rx_meta, r_rxs;
  logic [2:0]    r_state;
  logic [15:0]   r_cnt, r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_push;
  logic [CW-1:0] r_wptr, r_rptr;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic          r_ovf, r_ferr;
  logic          r_ready;
  logic [31:0]   r_rdata;

  logic [CW-1:0] w_count;
  logic [8:0]    w_count9;
  logic          w_empty, w_full, w_busy, w_cnt_zero;
  logic          w_access, w_read, w_pop, w_push_ok, w_ovf_set, w_ferr_set;
  logic          w_stat_wr, w_div_wr;
  logic [7:0]    w_head;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  assign w_count    = r_wptr - r_rptr;
  assign w_count9   = 9'(w_count);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (w_count == CW'(FIFO_DEPTH));
  assign w_busy     = (r_state != S_IDLE);
  assign w_cnt_zero = (r_cnt == 16'd0);
  assign w_head     = r_mem[r_rptr[AW-1:0]];

  assign w_access  = valid & ~r_ready;
  assign w_read    = w_access & (wstrb == 4'b0000);
  assign w_pop     = w_read & (addr == 2'd0) & ~w_empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign w_push_ok = r_push & (~w_full | w_pop);
  assign w_ovf_set = r_push & w_full & ~w_pop;
  assign w_ferr_set = (r_state == S_STOP) & w_cnt_zero & ~r_rxs;
  assign w_stat_wr = w_access & (addr == 2'd1) & wstrb[2];
  assign w_div_wr  = w_access & (addr == 2'd2) & (wstrb[1:0] == 2'b11);
  assign w_unused  = ^{wdata[31:18], wstrb[3]};

  always_comb begin
    w_rd_val = 32'd0;
    case (addr)
      2'd0:    w_rd_val = w_empty ? 32'hFFFF_FFFF : {24'd0, w_head};
      2'd1:    w_rd_val = {7'd0, w_busy, 6'd0, r_ferr, r_ovf, 7'd0, w_count9};
      2'd2:    w_rd_val = {16'd0, r_div};
      default: w_rd_val = 32'd0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= ser_rx;
      r_rxs     <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_push  <= 1'b0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            r_cnt   <= r_div >> 1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (!r_rxs) begin
            r_cnt   <= r_div - 16'd1;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else begin
            r_shift <= {r_rxs, r_shift[7:1]};
            r_cnt   <= r_div - 16'd1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 16'd1;
          end else if (r_rxs) begin
            r_push  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_state <= S_WAITHI;
          end
        end
        S_WAITHI: begin
          if (r_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_ferr <= 1'b0;
      r_div  <= 16'(DEFAULT_DIV);
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)     r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
      if (w_ovf_set)                       r_ovf <= 1'b1;
      else if (w_stat_wr && wdata[16])     r_ovf <= 1'b0;
      if (w_ferr_set)                      r_ferr <= 1'b1;
      else if (w_stat_wr && wdata[17])     r_ferr <= 1'b0;
      if (w_div_wr) r_div <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_ready <= valid & ~r_ready;
      if (w_access) r_rdata <= w_read ? w_rd_val : 32'd0;
    end
  end

  assign ready = r_ready;
  assign rdata = r_rdata;
  assign irq   = ~w_empty;

endmodule

// File: tb/tb_midiuart_rx.sv
// Scoreboard bench for midiuart_rx: bus reads queue their expected data and a
// monitor compares rdata whenever ready is seen.
`timescale 1ns/1ps
module tb_midiuart_rx;

  logic        clk = 1'b0;
  logic        reset, ser_rx, valid;
  logic [1:0]  addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready, irq;
  logic [31:0] rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [32:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  midiuart_rx #(.DEFAULT_DIV(1333), .FIFO_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .ser_rx(ser_rx), .valid(valid), .ready(ready),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every acknowledge pops one expectation.
  initial begin : monitor
    logic [32:0] e;
    string       nm;
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_ack: rdata %h with no pending transaction", rdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (e[32]) check(nm, rdata, e[31:0]);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus(input logic [1:0] a, input logic [3:0] ws, input logic [31:0] wd,
                     input logic care, input logic [31:0] exp, input string nm);
    @(negedge clk);
    addr  = a;
    wstrb = ws;
    wdata = wd;
    valid = 1'b1;
    exp_q.push_back({care, exp});
    name_q.push_back(nm);
    @(posedge clk); #1;
    check({nm, "_ack"}, 32'(ready), 32'd1);
    valid = 1'b0;
    @(posedge clk); #1;
    check({nm, "_ack_once"}, 32'(ready), 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    bus(a, 4'b0000, 32'd0, 1'b1, exp, nm);
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] ws, input logic [31:0] wd, input string nm);
    bus(a, ws, wd, 1'b0, 32'd0, nm);
  endtask

  task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (div) @(negedge clk);
    end
    ser_rx = stop;
    repeat (div) @(negedge clk);
  endtask

  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_DIV = 2'd2, A_RSV = 2'd3;

  initial begin : stim
    int          acks;
    logic [7:0]  pb;

    reset = 1'b0; ser_rx = 1'b1; valid = 1'b0;
    addr = 2'd0; wstrb = 4'd0; wdata = 32'd0;
    #2 reset = 1'b1;
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    rd(A_DIV, 32'd1333, "div_default");
    rd(A_STAT, 32'd0, "status_reset");
    wr(A_DIV, 4'b0011, 32'd2, "div_wr_small");
    rd(A_DIV, 32'd4, "div_clamp");
    wr(A_DIV, 4'b0011, 32'd16, "div_wr16");
    rd(A_DIV, 32'd16, "div_16");
    wr(A_RSV, 4'b1111, 32'hDEAD_BEEF, "rsv_wr");
    rd(A_RSV, 32'd0, "rsv_rd");

    // Single frame
    send_frame(8'h90, 16, 1'b1);
    check("single_irq", 32'(irq), 32'd1);
    rd(A_STAT, 32'h0000_0001, "single_status");
    wr(A_DATA, 4'b1111, 32'h0000_0077, "data_wr_ignored");
    rd(A_DATA, 32'h0000_0090, "single_data");
    rd(A_STAT, 32'd0, "single_status_after");
    check("single_irq_after", 32'(irq), 32'd0);

    // Empty read
    rd(A_DATA, 32'hFFFF_FFFF, "empty_data");
    rd(A_STAT, 32'd0, "empty_status");

    // Valid held across back-to-back transactions
    @(negedge clk);
    addr = A_STAT; wstrb = 4'd0; valid = 1'b1;
    exp_q.push_back({1'b1, 32'd0}); name_q.push_back("held_status0");
    exp_q.push_back({1'b1, 32'd0}); name_q.push_back("held_status1");
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready === 1'b1) acks++;
    end
    valid = 1'b0;
    check("held_valid_acks", 32'(acks), 32'd2);

    // Overflow
    for (int i = 0; i < 17; i++) send_frame(8'(i), 16, 1'b1);
    rd(A_STAT, 32'h0001_0010, "ovf_status");
    for (int i = 0; i < 16; i++) rd(A_DATA, 32'(i), "ovf_data");
    rd(A_DATA, 32'hFFFF_FFFF, "ovf_drained");
    wr(A_STAT, 4'b0100, 32'h0001_0000, "ovf_clear");
    rd(A_STAT, 32'd0, "ovf_cleared");

    // Framing error then break
    send_frame(8'h3C, 16, 1'b0);
    repeat (20 * 16) @(negedge clk);
    rd(A_STAT, 32'h0102_0000, "break_status");
    repeat (20 * 16) @(negedge clk);
    ser_rx = 1'b1;
    repeat (10) @(negedge clk);
    rd(A_STAT, 32'h0002_0000, "break_released");
    wr(A_STAT, 4'b0100, 32'h0002_0000, "ferr_clear");
    rd(A_STAT, 32'd0, "ferr_cleared");
    send_frame(8'hF8, 16, 1'b1);
    check("after_break_irq", 32'(irq), 32'd1);
    rd(A_DATA, 32'h0000_00F8, "after_break_data");

    // Glitch
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (30) @(negedge clk);
    rd(A_STAT, 32'd0, "glitch_status");

    // Full FIFO with a pop on the push edge (push lands 157 edges after the start bit)
    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 16, 1'b1);
    rd(A_STAT, 32'h0000_0010, "full_status");
    fork
      send_frame(8'h55, 16, 1'b1);
      begin
        @(negedge clk);
        repeat (155) @(negedge clk);
        rd(A_DATA, 32'h0000_0020, "pushpop_data");
      end
    join
    repeat (5) @(negedge clk);
    rd(A_STAT, 32'h0000_0010, "pushpop_status");
    for (int i = 1; i < 16; i++) rd(A_DATA, 32'h20 + 32'(i), "pushpop_drain");
    rd(A_DATA, 32'h0000_0055, "pushpop_last");
    rd(A_STAT, 32'd0, "pushpop_empty");

    // Asynchronous reset mid-frame
    send_frame(8'h11, 16, 1'b1);
    rd(A_STAT, 32'h0000_0001, "prereset_status");
    pb = 8'h5A;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_rx = pb[i];
      repeat (16) @(negedge clk);
    end
    reset = 1'b1;
    ser_rx = 1'b1;
    #1;
    check("midreset_ready", 32'(ready), 32'd0);
    check("midreset_rdata", rdata, 32'd0);
    check("midreset_irq", 32'(irq), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd(A_DIV, 32'd1333, "postreset_div");
    rd(A_STAT, 32'd0, "postreset_status");
    rd(A_DATA, 32'hFFFF_FFFF, "postreset_empty");
    send_frame(8'hA5, 1333, 1'b1);
    check("slow_irq", 32'(irq), 32'd1);
    rd(A_DATA, 32'h0000_00A5, "slow_data");

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
